// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and encodings for the multicycle main control
//   state_t  : controller states (also exported on the debug state port)
//   iclass_t : instruction class produced by opcode_decode
//   OP_*     : RV32I major opcodes handled by the core
//   ALUOP_*  : ALUOp encodings toward ALU control
//   SRC_A_* / SRC_B_* : ALU operand mux selects
package control_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    MEM_ADDR  = 4'd4,
    MEM_READ  = 4'd5,
    MEM_WRITE = 4'd6,
    WB_ALU    = 4'd7,
    WB_MEM    = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;

  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_IMM   = 2'd1;
  localparam logic [1:0] SRC_B_FOUR  = 2'd2;

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - classifies a latched instruction and flags unsupported encodings
//   ir     in  32  latched instruction
//   iclass out 3   instruction class (R/I/LOAD/STORE/BRANCH)
//   legal  out 1   1 when the encoding is one the core executes
module opcode_decode
  import control_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     iclass,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

  // register and immediate fields do not affect classification
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    iclass = CLS_R;
    legal  = 1'b0;
    case (opcode)
      OP_R: begin
        iclass = CLS_R;
        // ADD / AND / OR with funct7=0, SUB with funct7=0100000
        legal  = ((f7 == 7'b0000000) && ((f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111))) ||
                 ((f7 == 7'b0100000) && (f3 == 3'b000));
      end
      OP_I: begin
        iclass = CLS_I;
        legal  = (f3 == 3'b000);
      end
      OP_LOAD: begin
        iclass = CLS_LOAD;
        legal  = (f3 == 3'b010);
      end
      OP_STORE: begin
        iclass = CLS_STORE;
        legal  = (f3 == 3'b010);
      end
      OP_BRANCH: begin
        iclass = CLS_BRANCH;
        legal  = (f3 == 3'b000) || (f3 == 3'b001);
      end
      default: begin
        iclass = CLS_R;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V main control FSM with instruction register
//   clk, rst          core clock, synchronous active-high reset
//   mem_rdata/ready   memory read data and request completion
//   alu_zero          ALU result is zero (branch compare)
//   mem_req/we        memory request and write qualifier
//   mem_addr_sel      memory address: 0=PC, 1=ALUOut
//   ir, funct3, funct7 latched instruction and its function fields
//   ALUOp             00 add, 01 sub, 10 R-type decode
//   alu_src_a/b       ALU operand selects
//   pc_write/pc_src   PC load enable and source
//   reg_write/wb_sel  register-file write enable and writeback source
//   illegal           sticky trap flag
//   state             current state for debug
module multicycle_control
  import control_pkg::*;
#(
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [31:0] ir,
  output logic [1:0]  ALUOp,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t     state_q;
  state_t     next_state;
  logic [31:0] ir_q;
  logic       ir_load;
  iclass_t    iclass;
  logic       legal;

  opcode_decode u_decode (
    .ir     (ir_q),
    .iclass (iclass),
    .legal  (legal)
  );

  // the instruction word is captured on the cycle the fetch completes
  assign ir_load = (state_q == FETCH) && mem_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= RESET_IR;
    end else begin
      state_q <= next_state;
      if (ir_load) begin
        ir_q <= mem_rdata;
      end
    end
  end

  assign ir     = ir_q;
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign state  = rst ? 4'd0 : state_q;

  always_comb begin
    next_state   = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ALUOp        = ALUOP_ADD;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // PC <= PC + 4 in the same cycle the instruction arrives
          pc_write   = 1'b1;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          ALUOp      = ALUOP_ADD;
          next_state = DECODE;
        end
      end

      DECODE: begin
        // oldPC + imm precomputes the branch target into ALUOut
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        ALUOp     = ALUOP_ADD;
        if (!legal) begin
          next_state = TRAP;
        end else begin
          case (iclass)
            CLS_R:      next_state = EXEC_R;
            CLS_I:      next_state = EXEC_I;
            CLS_LOAD:   next_state = MEM_ADDR;
            CLS_STORE:  next_state = MEM_ADDR;
            CLS_BRANCH: next_state = BRANCH;
            default:    next_state = TRAP;
          endcase
        end
      end

      EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        ALUOp      = ALUOP_RTYPE;
        next_state = WB_ALU;
      end

      EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        ALUOp      = ALUOP_ADD;
        next_state = WB_ALU;
      end

      WB_ALU: begin
        reg_write  = 1'b1;
        wb_sel     = 1'b0;
        next_state = FETCH;
      end

      MEM_ADDR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        ALUOp      = ALUOP_ADD;
        next_state = (iclass == CLS_STORE) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          next_state = WB_MEM;
        end
      end

      MEM_WRITE: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = 1'b1;
        if (mem_ready) begin
          next_state = FETCH;
        end
      end

      WB_MEM: begin
        reg_write  = 1'b1;
        wb_sel     = 1'b1;
        next_state = FETCH;
      end

      BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        ALUOp      = ALUOP_SUB;
        pc_src     = 1'b1;
        // funct3 bit 0 distinguishes BNE (001) from BEQ (000)
        pc_write   = ir_q[12] ? !alu_zero : alu_zero;
        next_state = FETCH;
      end

      TRAP: begin
        illegal    = 1'b1;
        next_state = TRAP;
      end

      default: begin
        next_state = TRAP;
      end
    endcase

    // reset silences every strobe immediately, aborting any pending request
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ALUOp        = ALUOP_ADD;
      alu_src_a    = SRC_A_PC;
      alu_src_b    = SRC_B_RS2;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule
